// File: rtl/bank_adr_walker_if.sv
// Handshake bundle for bank_adr_walker: the walk request channel and the
// global-address output channel. The walker connects through the slave modport.
interface bank_adr_walker_if #(
  parameter int BANK_IDX_W         = 4,
  parameter int LOG2_MAX_PARTITION = 2,
  parameter int BANK_ADR_WIDTH     = 32,
  parameter int CNT_W              = 16,
  parameter int XMEM_AW            = 32
);
  logic                          start_valid;
  logic                          start_ready;
  logic [BANK_IDX_W-1:0]         start_bankIdx;
  logic [LOG2_MAX_PARTITION-1:0] start_partIdx;
  logic [BANK_ADR_WIDTH-1:0]     start_bankAdr;
  logic [CNT_W-1:0]              start_count;

  logic                          out_valid;
  logic                          out_ready;
  logic [XMEM_AW-1:0]            out_adr;
  logic [BANK_ADR_WIDTH-1:0]     out_bankAdr;
  logic                          out_last;

  modport master (
    output start_valid, start_bankIdx, start_partIdx, start_bankAdr, start_count,
    output out_ready,
    input  start_ready,
    input  out_valid, out_adr, out_bankAdr, out_last
  );

  modport slave (
    input  start_valid, start_bankIdx, start_partIdx, start_bankAdr, start_count,
    input  out_ready,
    output start_ready,
    output out_valid, out_adr, out_bankAdr, out_last
  );
endinterface

// File: rtl/bank_adr_walker.sv
// Inverse xcache bank-address map: walks a bank-local range one word at a time
// and emits the global XMEM address of each word (SCALAR interleave or ARRAY blocks).
module bank_adr_walker #(
  parameter string RANGE_TYPE         = "SCALAR",
  parameter int    BANK_ADR_WIDTH     = 32,
  parameter int    BANK_IDX_W         = 4,
  parameter int    CNT_W              = 16,
  parameter int    XMEM_AW            = 32,
  parameter int    MAX_PARTITION      = 4,
  parameter int    LOG2_MAX_PARTITION = 2,
  parameter int    BANK_NUM           = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  bank_adr_walker_if.slave                       bus,
  input  logic                                   abort,
  input  logic [MAX_PARTITION-1:0][XMEM_AW-1:0]  subRangeStart,
  input  logic [MAX_PARTITION-1:0][XMEM_AW-1:0]  subBankStart,
  input  logic [MAX_PARTITION-1:0][XMEM_AW-1:0]  subBankSize,
  output logic                                   busy
);

  localparam bit IS_SCALAR = (RANGE_TYPE == "SCALAR");
  localparam int SHW       = (XMEM_AW > 1) ? $clog2(XMEM_AW) : 1;

  localparam logic [BANK_ADR_WIDTH-1:0] ALIGN_B    = ~BANK_ADR_WIDTH'(3);
  localparam logic [BANK_ADR_WIDTH-1:0] FOUR_B     = BANK_ADR_WIDTH'(4);
  localparam logic [XMEM_AW-1:0]        BANK_NUM_X = XMEM_AW'(BANK_NUM);
  localparam logic [XMEM_AW-1:0]        STEP_X     = XMEM_AW'(4 * BANK_NUM);
  localparam logic [CNT_W-1:0]          CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]          CNT_TWO    = CNT_W'(2);

  typedef enum logic [1:0] {IDLE, SETUP, RUN} state_t;

  state_t                    state_reg;
  logic                      start_ready_reg;
  logic                      busy_reg;
  logic                      out_valid_reg;
  logic                      out_last_reg;
  logic [XMEM_AW-1:0]        out_adr_reg;
  logic [BANK_ADR_WIDTH-1:0] out_bank_adr_reg;

  logic [BANK_IDX_W-1:0]     bank_idx_reg;
  logic [BANK_ADR_WIDTH-1:0] bank_adr_reg;
  logic [BANK_ADR_WIDTH-1:0] local_reg;
  logic [CNT_W-1:0]          count_reg;
  logic [XMEM_AW-1:0]        range_start_reg;
  logic [XMEM_AW-1:0]        bank_start_reg;
  logic [XMEM_AW-1:0]        bank_size_reg;
  logic [XMEM_AW-1:0]        base_reg;

  logic [LOG2_MAX_PARTITION-1:0] part_sel;

  logic [XMEM_AW-1:0]        first_adr;
  logic [XMEM_AW-1:0]        first_base;
  logic [BANK_ADR_WIDTH-1:0] first_local;
  logic [BANK_ADR_WIDTH-1:0] first_bank_adr;
  logic [XMEM_AW-1:0]        next_adr;
  logic [BANK_ADR_WIDTH-1:0] next_local;
  logic [BANK_ADR_WIDTH-1:0] next_bank_adr;

  // ARRAY mode has a single config entry, so the partition index is ignored there.
  assign part_sel = IS_SCALAR ? bus.start_partIdx : '0;

  generate
    if (IS_SCALAR) begin : g_scalar
      logic [BANK_ADR_WIDTH-1:0] sbs_b;
      logic                      unused_cfg;

      assign sbs_b          = BANK_ADR_WIDTH'(bank_start_reg);
      assign first_local    = bank_adr_reg & ~sbs_b & ALIGN_B;
      // Constant multiply, only evaluated for the first word; later words just add STEP_X.
      assign first_adr      = ((XMEM_AW'(first_local >> 2) * BANK_NUM_X)
                              + XMEM_AW'(bank_idx_reg)) << 2;
      assign first_base     = '0;
      assign first_bank_adr = first_local | sbs_b;
      assign next_local     = local_reg + FOUR_B;
      assign next_bank_adr  = (next_local & ALIGN_B) | sbs_b;
      assign next_adr       = out_adr_reg + STEP_X;
      assign unused_cfg     = ^{range_start_reg, bank_size_reg, base_reg};
    end else begin : g_array
      logic [XMEM_AW-1:0]        mask;
      logic [BANK_ADR_WIDTH-1:0] mask_b;
      logic [SHW-1:0]            sh;
      logic                      unused_cfg;

      assign mask   = bank_size_reg - XMEM_AW'(1);
      assign mask_b = BANK_ADR_WIDTH'(mask);

      // Highest set bit of the (power-of-two) bank size gives the bank-index shift.
      always_comb begin
        sh = '0;
        for (int i = 0; i < XMEM_AW; i++) begin
          if (bank_size_reg[i]) sh = SHW'(i);
        end
      end

      assign first_base     = range_start_reg | (XMEM_AW'(bank_idx_reg) << sh);
      assign first_local    = bank_adr_reg & ALIGN_B & mask_b;
      assign first_adr      = first_base | XMEM_AW'(first_local);
      assign first_bank_adr = first_local;
      // Masking keeps the walk inside the bank: it wraps rather than touching the index bits.
      assign next_local     = (local_reg + FOUR_B) & mask_b;
      assign next_adr       = base_reg | XMEM_AW'(next_local);
      assign next_bank_adr  = next_local;
      assign unused_cfg     = ^{bank_start_reg};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      start_ready_reg  <= 1'b0;
      busy_reg         <= 1'b0;
      out_valid_reg    <= 1'b0;
      out_last_reg     <= 1'b0;
      out_adr_reg      <= '0;
      out_bank_adr_reg <= '0;
      bank_idx_reg     <= '0;
      bank_adr_reg     <= '0;
      local_reg        <= '0;
      count_reg        <= '0;
      range_start_reg  <= '0;
      bank_start_reg   <= '0;
      bank_size_reg    <= '0;
      base_reg         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          start_ready_reg <= 1'b1;
          if (bus.start_valid && start_ready_reg) begin
            state_reg       <= SETUP;
            start_ready_reg <= 1'b0;
            busy_reg        <= 1'b1;
            bank_idx_reg    <= bus.start_bankIdx;
            bank_adr_reg    <= bus.start_bankAdr;
            count_reg       <= bus.start_count;
            range_start_reg <= subRangeStart[part_sel];
            bank_start_reg  <= subBankStart[part_sel];
            bank_size_reg   <= subBankSize[part_sel];
          end
        end

        SETUP: begin
          if (abort || (count_reg == '0)) begin
            state_reg       <= IDLE;
            start_ready_reg <= 1'b1;
            busy_reg        <= 1'b0;
          end else begin
            state_reg        <= RUN;
            out_valid_reg    <= 1'b1;
            out_last_reg     <= (count_reg == CNT_ONE);
            out_adr_reg      <= first_adr;
            out_bank_adr_reg <= first_bank_adr;
            local_reg        <= first_local;
            base_reg         <= first_base;
          end
        end

        RUN: begin
          if (abort || (bus.out_ready && out_last_reg)) begin
            state_reg       <= IDLE;
            start_ready_reg <= 1'b1;
            busy_reg        <= 1'b0;
            out_valid_reg   <= 1'b0;
            out_last_reg    <= 1'b0;
          end else if (bus.out_ready) begin
            count_reg        <= count_reg - CNT_ONE;
            out_last_reg     <= (count_reg == CNT_TWO);
            out_adr_reg      <= next_adr;
            out_bank_adr_reg <= next_bank_adr;
            local_reg        <= next_local;
          end
        end

        default: begin
          state_reg       <= IDLE;
          start_ready_reg <= 1'b0;
          busy_reg        <= 1'b0;
          out_valid_reg   <= 1'b0;
          out_last_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start_ready = start_ready_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_last    = out_last_reg;
  assign bus.out_adr     = out_adr_reg;
  assign bus.out_bankAdr = out_bank_adr_reg;
  assign busy            = busy_reg;

endmodule
